// File: rtl/uart_cipo_rx_pkg.sv
// Shared definitions for the UART receive path.
// rx_state_e carries the 2-bit state codes that the transmitter also uses, so both ends of the
// link report state identically: IDLE 00, START 10, DATA 01, STOP 11.
// DataBits is the number of payload bits in one 8N1 frame.
package uart_cipo_rx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b10,
    StData  = 2'b01,
    StStop  = 2'b11
  } rx_state_e;

  localparam int unsigned DataBits = 8;

endpackage

// File: rtl/uart_cipo_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Ports:
//   clk   - receive clock
//   reset - synchronous, active-high; both flops reset to 1 (idle line level)
//   d     - asynchronous input
//   q     - synchronised output, two cycles behind d
module uart_cipo_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_cipo_rx.sv
// 8N1 UART receiver with a valid/ack output buffer.
// The line is synchronised, a falling edge in IDLE starts a frame, the start bit is re-checked
// half a bit later, then each data bit and the stop bit are sampled one bit period apart.
// Ports:
//   CLK             - clock, all logic on the rising edge
//   RESET           - synchronous, active-high reset
//   SER_DATA        - asynchronous serial input, idle high
//   OUTPUT_DATA_REG - last delivered byte, stable while DATA_VALID is high
//   DATA_VALID      - byte waiting to be taken, held until acknowledged
//   DATA_ACK        - consumer takes the byte in any cycle with DATA_VALID high
//   FRAME_ERR       - one-cycle pulse when the stop bit is sampled low
//   OVERRUN         - one-cycle pulse when a good byte is dropped because the buffer is full
//   STATE           - current receiver state code
module uart_cipo_rx
  import uart_cipo_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SER_DATA,
  output logic [7:0] OUTPUT_DATA_REG,
  output logic       DATA_VALID,
  input  logic       DATA_ACK,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic [1:0] STATE
);

  localparam logic [7:0] HalfLast = 8'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] BitLast  = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LastBit  = 3'(DataBits - 1);

  rx_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;
  logic       rx_s;
  logic       rx_p_q;

  uart_cipo_sync u_sync (
    .clk   (CLK),
    .reset (RESET),
    .d     (SER_DATA),
    .q     (rx_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    // A plain acknowledge empties the buffer; a delivery below overrides this.
    if (valid_q && DATA_ACK) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // Edge only, so a line held low (break) never retriggers.
        if (!rx_s && rx_p_q) begin
          state_d = StStart;
          cnt_d   = 8'd0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          if (rx_s) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            cnt_d     = 8'd0;
            bit_idx_d = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          cnt_d     = 8'd0;
          if (bit_idx_q == LastBit) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
          if (!rx_s) begin
            ferr_d = 1'b1;
          end else if (!valid_q || DATA_ACK) begin
            // Buffer is free, or is being emptied in this very cycle.
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      rx_p_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      rx_p_q    <= rx_s;
    end
  end

  assign OUTPUT_DATA_REG = data_q;
  assign DATA_VALID      = valid_q;
  assign FRAME_ERR       = ferr_q;
  assign OVERRUN         = ovr_q;
  assign STATE           = state_q;

endmodule

// File: tb/tb_uart_cipo_rx.sv
// Bench for uart_cipo_rx: one receiver at 16 clocks/bit, one at 3 clocks/bit.
// The reference model works at frame level: each transmitted frame schedules one outcome
// (deliver / frame error) at a fixed latency after its start edge, and the model applies the
// buffer rules (deliver if free or being acked, else overrun) to that schedule.
`timescale 1ns/1ps
module tb_uart_cipo_rx;

  localparam int Cpb0 = 16;
  localparam int Cpb1 = 3;
  localparam int MaxEv = 64;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic       rst     [2];
  logic       ser     [2];
  logic       ack_man [2];
  logic       ack_rnd [2];
  logic       rnd_en  [2];
  logic       ack     [2];
  logic [7:0] od      [2];
  logic       dv      [2];
  logic       fe      [2];
  logic       ov      [2];
  logic [1:0] st      [2];

  assign ack[0] = ack_man[0] | (rnd_en[0] & ack_rnd[0]);
  assign ack[1] = ack_man[1] | (rnd_en[1] & ack_rnd[1]);

  uart_cipo_rx #(.CLKS_PER_BIT(Cpb0)) u_rx16 (
    .CLK             (clk),
    .RESET           (rst[0]),
    .SER_DATA        (ser[0]),
    .OUTPUT_DATA_REG (od[0]),
    .DATA_VALID      (dv[0]),
    .DATA_ACK        (ack[0]),
    .FRAME_ERR       (fe[0]),
    .OVERRUN         (ov[0]),
    .STATE           (st[0])
  );

  uart_cipo_rx #(.CLKS_PER_BIT(Cpb1)) u_rx3 (
    .CLK             (clk),
    .RESET           (rst[1]),
    .SER_DATA        (ser[1]),
    .OUTPUT_DATA_REG (od[1]),
    .DATA_VALID      (dv[1]),
    .DATA_ACK        (ack[1]),
    .FRAME_ERR       (fe[1]),
    .OVERRUN         (ov[1]),
    .STATE           (st[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Frame schedule, appended by stimulus, consumed in order by the model.
  int         ev_at [2][MaxEv];
  logic [7:0] ev_b  [2][MaxEv];
  logic       ev_ok [2][MaxEv];
  int         n_ev  [2];
  int         rd    [2];
  int         start_c  [2];
  logic       false_st [2];

  logic       m_valid [2];
  logic [7:0] m_data  [2];
  logic       m_fe    [2];
  logic       m_ov    [2];
  int         rst_cyc [2];

  int         rise_cyc  [2];
  int         fe_cnt    [2];
  int         ov_cnt    [2];
  int         start_cnt [2];
  logic       dv_prev   [2];
  logic [1:0] st_prev   [2];

  function automatic int cpb(input int k);
    return (k == 0) ? Cpb0 : Cpb1;
  endfunction

  // Posedges from the one that first samples the start bit to the one that raises DATA_VALID,
  // counting both.
  function automatic int lat(input int k);
    return 3 + cpb(k) / 2 + 9 * cpb(k);
  endfunction

  // Frame phases measured from the first sampling posedge: two synchroniser cycles, half a bit
  // to the start-bit centre, eight data bits, one stop bit.
  function automatic logic [1:0] exp_state(input int k);
    int h;
    int j;
    h = cpb(k) / 2;
    if (start_c[k] < 0 || start_c[k] <= rst_cyc[k]) return 2'b00;
    j = cyc - start_c[k];
    if (j < 2) return 2'b00;
    if (j < 2 + h) return 2'b10;
    if (false_st[k]) return 2'b00;
    if (j < 2 + h + 8 * cpb(k)) return 2'b01;
    if (j < 2 + h + 9 * cpb(k)) return 2'b11;
    return 2'b00;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s rx%0d cyc=%0d got=%0h want=%0h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int k);
    logic v0;
    logic delivered;
    v0 = m_valid[k];
    delivered = 1'b0;
    m_fe[k] = 1'b0;
    m_ov[k] = 1'b0;
    if (rst[k]) begin
      m_valid[k] = 1'b0;
      m_data[k]  = 8'h00;
      rst_cyc[k] = cyc;
      rd[k]      = n_ev[k];
      return;
    end
    if (rd[k] < n_ev[k] && ev_at[k][rd[k]] == cyc) begin
      if (ev_ok[k][rd[k]]) begin
        if (!v0 || ack[k]) begin
          m_data[k]  = ev_b[k][rd[k]];
          m_valid[k] = 1'b1;
          delivered  = 1'b1;
        end else begin
          m_ov[k] = 1'b1;
        end
      end else begin
        m_fe[k] = 1'b1;
      end
      rd[k]++;
    end
    if (v0 && ack[k] && !delivered) m_valid[k] = 1'b0;
  endtask

  task automatic compare(input int k);
    chk("data_valid", k, 32'(dv[k]), 32'(m_valid[k]));
    chk("data_reg", k, 32'(od[k]), 32'(m_data[k]));
    chk("frame_err", k, 32'(fe[k]), 32'(m_fe[k]));
    chk("overrun", k, 32'(ov[k]), 32'(m_ov[k]));
    chk("state", k, 32'(st[k]), 32'(exp_state(k)));
    if (dv[k] === 1'b1 && dv_prev[k] !== 1'b1) rise_cyc[k] = cyc;
    if (fe[k] === 1'b1) fe_cnt[k]++;
    if (ov[k] === 1'b1) ov_cnt[k]++;
    if (st[k] === 2'b10 && st_prev[k] !== 2'b10) start_cnt[k]++;
    dv_prev[k] = dv[k];
    st_prev[k] = st[k];
  endtask

  // Model and per-cycle compare; outputs sampled 1ns after the active edge.
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0; m_data[k] = 8'h00; m_fe[k] = 1'b0; m_ov[k] = 1'b0;
      rst_cyc[k] = -1000; rd[k] = 0; rise_cyc[k] = -1;
      fe_cnt[k] = 0; ov_cnt[k] = 0; start_cnt[k] = 0;
      dv_prev[k] = 1'b0; st_prev[k] = 2'b00;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) model_step(k);
      #1;
      for (int k = 0; k < 2; k++) compare(k);
    end
  end

  initial begin
    ack_rnd[0] = 1'b0;
    ack_rnd[1] = 1'b0;
    forever begin
      @(negedge clk);
      ack_rnd[0] = ($urandom_range(0, 3) == 0);
      ack_rnd[1] = ($urandom_range(0, 3) == 0);
    end
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic push_ev(input int k, input int at, input logic [7:0] b, input logic ok);
    ev_at[k][n_ev[k]] = at;
    ev_b[k][n_ev[k]]  = b;
    ev_ok[k][n_ev[k]] = ok;
    n_ev[k]++;
  endtask

  task automatic send_frame(input int k, input logic [7:0] b, input logic sb);
    int c;
    c = cpb(k);
    start_c[k]  = cyc + 1;
    false_st[k] = 1'b0;
    push_ev(k, cyc + lat(k), b, sb);
    ser[k] = 1'b0;
    repeat (c) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser[k] = b[i];
      repeat (c) @(negedge clk);
    end
    ser[k] = sb;
    repeat (c) @(negedge clk);
  endtask

  task automatic idle(input int k, input int n);
    ser[k] = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse(input int k);
    ack_man[k] = 1'b1;
    @(negedge clk);
    ack_man[k] = 1'b0;
  endtask

  task automatic wait_until(input int target);
    int n;
    n = 0;
    while (cyc < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cyc < target) begin
      failures++;
      $display("FAIL wait_bound cyc=%0d want=%0d", cyc, target);
    end
  endtask

  task automatic random_phase(input int k, input int nframes);
    logic [7:0] b;
    logic       sb;
    int         gap;
    rnd_en[k] = 1'b1;
    for (int n = 0; n < nframes; n++) begin
      b   = 8'($urandom);
      sb  = ($urandom_range(0, 5) != 0);
      send_frame(k, b, sb);
      gap = sb ? $urandom_range(0, 12) : $urandom_range(1, 12);
      idle(k, gap);
    end
    idle(k, 20);
    rnd_en[k] = 1'b0;
    idle(k, 5);
  endtask

  int s, s1, s2, f, o, sc, lat1;
  logic [7:0] d1;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; ser[k] = 1'b1; ack_man[k] = 1'b0; rnd_en[k] = 1'b0;
      start_c[k] = -1; false_st[k] = 1'b0; n_ev[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_state", 0, 32'(st[0]), 32'h0);
    chk("reset_valid", 0, 32'(dv[0]), 32'h0);
    chk("reset_data", 0, 32'(od[0]), 32'h00);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    idle(0, 5);

    // Single frame, latency and acknowledge.
    s = cyc + 1;
    send_frame(0, 8'hA5, 1'b1);
    idle(0, 10);
    chk("t1_latency", 0, 32'(rise_cyc[0] - s + 1), 32'd155);
    chk("t1_data", 0, 32'(od[0]), 32'hA5);
    chk("t1_valid", 0, 32'(dv[0]), 32'h1);
    ack_pulse(0);
    chk("t1_ack_clears", 0, 32'(dv[0]), 32'h0);
    chk("t1_data_kept", 0, 32'(od[0]), 32'hA5);

    // Short low glitch: false start.
    sc = start_cnt[0];
    f  = fe_cnt[0];
    start_c[0]  = cyc + 1;
    false_st[0] = 1'b1;
    ser[0] = 1'b0;
    repeat (4) @(negedge clk);
    idle(0, 30);
    chk("t2_start_seen", 0, 32'(start_cnt[0] - sc), 32'd1);
    chk("t2_state_idle", 0, 32'(st[0]), 32'h0);
    chk("t2_no_valid", 0, 32'(dv[0]), 32'h0);
    chk("t2_no_ferr", 0, 32'(fe_cnt[0] - f), 32'd0);

    // Bad stop bit followed by a break, then a good frame.
    f = fe_cnt[0];
    send_frame(0, 8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    idle(0, 20);
    chk("t3_ferr_once", 0, 32'(fe_cnt[0] - f), 32'd1);
    chk("t3_no_valid", 0, 32'(dv[0]), 32'h0);
    s = cyc + 1;
    send_frame(0, 8'h01, 1'b1);
    idle(0, 10);
    chk("t3_data", 0, 32'(od[0]), 32'h01);
    chk("t3_latency", 0, 32'(rise_cyc[0] - s + 1), 32'd155);
    ack_pulse(0);

    // Back-to-back without ack: overrun keeps the first byte.
    o = ov_cnt[0];
    send_frame(0, 8'h11, 1'b1);
    send_frame(0, 8'h22, 1'b1);
    idle(0, 20);
    chk("t4_kept_first", 0, 32'(od[0]), 32'h11);
    chk("t4_overrun_once", 0, 32'(ov_cnt[0] - o), 32'd1);
    chk("t4_valid", 0, 32'(dv[0]), 32'h1);
    ack_pulse(0);
    chk("t4_ack_clears", 0, 32'(dv[0]), 32'h0);

    // Back-to-back with ack in the second stop-sample cycle.
    o = ov_cnt[0];
    send_frame(0, 8'h11, 1'b1);
    s2 = cyc + 1;
    fork
      send_frame(0, 8'h22, 1'b1);
      begin
        wait_until(s2 + lat(0) - 2);
        ack_pulse(0);
      end
    join
    idle(0, 10);
    chk("t4b_second", 0, 32'(od[0]), 32'h22);
    chk("t4b_valid", 0, 32'(dv[0]), 32'h1);
    chk("t4b_no_overrun", 0, 32'(ov_cnt[0] - o), 32'd0);
    ack_pulse(0);

    // Reset during data bit 4 of 0x5A.
    start_c[0]  = cyc + 1;
    false_st[0] = 1'b0;
    push_ev(0, cyc + lat(0), 8'h5A, 1'b1);
    d1 = 8'h5A;
    ser[0] = 1'b0;
    repeat (Cpb0) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ser[0] = d1[i];
      repeat (Cpb0) @(negedge clk);
    end
    ser[0] = d1[4];
    repeat (Cpb0 / 2) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("t5_state", 0, 32'(st[0]), 32'h0);
    chk("t5_valid", 0, 32'(dv[0]), 32'h0);
    chk("t5_data", 0, 32'(od[0]), 32'h00);
    chk("t5_ferr", 0, 32'(fe[0]), 32'h0);
    chk("t5_overrun", 0, 32'(ov[0]), 32'h0);
    idle(0, 200);
    s = cyc + 1;
    send_frame(0, 8'h5A, 1'b1);
    idle(0, 10);
    chk("t5_fresh_data", 0, 32'(od[0]), 32'h5A);
    chk("t5_fresh_latency", 0, 32'(rise_cyc[0] - s + 1), 32'd155);
    ack_pulse(0);

    random_phase(0, 12);

    // Three clocks per bit, frames at exact bit timing.
    idle(1, 5);
    s1 = cyc + 1;
    fork
      begin
        send_frame(1, 8'hFF, 1'b1);
        send_frame(1, 8'h00, 1'b1);
      end
      begin
        wait_until(s1 + lat(1) - 1);
        lat1 = rise_cyc[1] - s1 + 1;
        d1   = od[1];
        ack_pulse(1);
      end
    join
    idle(1, 10);
    chk("t6_first_latency", 1, 32'(lat1), 32'd31);
    chk("t6_first_data", 1, 32'(d1), 32'hFF);
    chk("t6_second_latency", 1, 32'(rise_cyc[1] - (s1 + 30) + 1), 32'd31);
    chk("t6_second_data", 1, 32'(od[1]), 32'h00);
    chk("t6_valid", 1, 32'(dv[1]), 32'h1);
    ack_pulse(1);

    random_phase(1, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
